lsu_ctrl: RTL and testbench

Load/store unit sitting between the datapath's MEM stage and `data_mem`. It converts RISC-V load/store requests (byte/half/word, signed/unsigned) into word-aligned memory accesses with per-byte write enables, lane-shifted write data and load extraction/sign-extension. Accesses that cross a word boundary are split into two memory beats by a small FSM that stalls the requester.

---
 rtl/lsu_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit between MEM stage and data_mem: byte-lane write enables, lane-shifted
// store data and load extraction. `LSU_MISALIGN_SPLIT_EN` enables two-beat split accesses.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic       en,
  input  logic [3:0] lo,
  input  logic [3:0] hi,
  output logic       we
);
  localparam logic [3:0] L = 4'(LANE);
  assign we = en && (L >= lo) && (L <= hi);
endmodule

module lsu_ctrl #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     misaligned_err,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  output logic                     mem_WE0,
  output logic                     mem_WE1,
  output logic                     mem_WE2,
  output logic                     mem_WE3,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);
  localparam int AW = ADDRESS_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] ext(input logic [2:0] f3, input logic [DATA_WIDTH-1:0] d);
    case (f3)
      3'b000:  ext = {{24{d[7]}}, d[7:0]};
      3'b001:  ext = {{16{d[15]}}, d[15:0]};
      3'b100:  ext = {24'b0, d[7:0]};
      3'b101:  ext = {16'b0, d[15:0]};
      default: ext = d;
    endcase
  endfunction

  logic [1:0]            off;
  logic [2:0]            size;
  logic                  legal, split_cls, accept;
  logic [3:0]            last;
  logic [AW-1:0]         a_al;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic [3:0]            lane_lo, lane_hi;
  logic                  lane_en;
  logic [3:0]            we;

  assign off    = req_addr[1:0];
  assign a_al   = {req_addr[AW-1:2], 2'b00};
  assign rd_sh  = mem_RD >> {off, 3'b000};
  assign accept = req_valid && req_ready;

  always_comb begin
    size  = 3'd1;
    legal = 1'b0;
    case (req_funct3)
      3'b000: begin size = 3'd1; legal = 1'b1;       end
      3'b001: begin size = 3'd2; legal = 1'b1;       end
      3'b010: begin size = 3'd4; legal = 1'b1;       end
      3'b100: begin size = 3'd1; legal = !req_store; end
      3'b101: begin size = 3'd2; legal = !req_store; end
      default: ;
    endcase
  end

  // last byte lane touched; anything beyond lane 3 spills into the next word
  assign last      = {2'b00, off} + {1'b0, size} - 4'd1;
  assign split_cls = legal && (last > 4'd3);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (.en(lane_en), .lo(lane_lo), .hi(lane_hi), .we(we[i]));
  end

  assign {mem_WE3, mem_WE2, mem_WE1, mem_WE0} = we;

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE, BEAT2} state_t;

  state_t                state;
  logic [AW-1:0]         addr_r;
  logic [2:0]            f3_r;
  logic                  store_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] lo_r;
  logic [1:0]            off_r;
  logic [2:0]            size_r;
  logic [3:0]            last_r;
  logic [2:0]            sh2;
  logic [DATA_WIDTH-1:0] asm_rd;

  assign req_ready      = (state == IDLE);
  assign misaligned_err = 1'b0;
  assign last_r         = {2'b00, off_r} + {1'b0, size_r} - 4'd1;
  assign sh2            = 3'd4 - {1'b0, off_r};
  // beat-1 bytes sit low in lo_r; beat-2 bytes are placed just above them
  assign asm_rd         = lo_r | (mem_RD << {sh2, 3'b000});

  always_comb begin
    mem_A   = a_al;
    mem_WD  = req_wdata << {off, 3'b000};
    lane_lo = {2'b00, off};
    lane_hi = split_cls ? 4'd3 : last;
    lane_en = accept && legal && req_store;
    if (state == BEAT2) begin
      mem_A   = addr_r;
      mem_WD  = wdata_r >> {sh2, 3'b000};
      lane_lo = 4'd0;
      lane_hi = last_r - 4'd4;
      lane_en = store_r;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      addr_r    <= '0;
      f3_r      <= '0;
      store_r   <= 1'b0;
      wdata_r   <= '0;
      lo_r      <= '0;
      off_r     <= '0;
      size_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          if (accept) begin
            if (split_cls) begin
              state   <= BEAT2;
              addr_r  <= a_al + AW'(4);
              f3_r    <= req_funct3;
              store_r <= req_store;
              wdata_r <= req_wdata;
              lo_r    <= rd_sh;
              off_r   <= off;
              size_r  <= size;
            end else begin
              rsp_valid <= 1'b1;
              if (legal && !req_store) rsp_rdata <= ext(req_funct3, rd_sh);
            end
          end
        end
        BEAT2: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= store_r ? '0 : ext(f3_r, asm_rd);
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign req_ready = 1'b1;

  always_comb begin
    mem_A   = a_al;
    mem_WD  = req_wdata << {off, 3'b000};
    lane_lo = {2'b00, off};
    lane_hi = last;
    lane_en = accept && legal && req_store && !split_cls;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      misaligned_err <= 1'b0;
    end else begin
      rsp_valid      <= accept;
      rsp_rdata      <= '0;
      misaligned_err <= accept && split_cls;
      if (accept && legal && !split_cls && !req_store) rsp_rdata <= ext(req_funct3, rd_sh);
    end
  end
`endif
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed memory model; split tests
// run when LSU_MISALIGN_SPLIT_EN is defined, misaligned-error tests otherwise.
module tb_lsu_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [16:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned_err;
  logic [16:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE0, mem_WE1, mem_WE2, mem_WE3;
  logic [31:0] mem_RD;
  logic [3:0]  we;
  logic [7:0]  mem [0:131071];
  int          n_cmp = 0;
  int          n_err = 0;

  lsu_ctrl #(.ADDRESS_WIDTH(17), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misaligned_err(misaligned_err), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_WE0(mem_WE0), .mem_WE1(mem_WE1), .mem_WE2(mem_WE2), .mem_WE3(mem_WE3),
    .mem_RD(mem_RD)
  );

  always #5 CLK = ~CLK;

  assign we     = {mem_WE3, mem_WE2, mem_WE1, mem_WE0};
  assign mem_RD = {mem[17'(mem_A + 17'd3)], mem[17'(mem_A + 17'd2)],
                   mem[17'(mem_A + 17'd1)], mem[mem_A]};

  always @(posedge CLK) begin
    if (mem_WE0) mem[mem_A]                <= mem_WD[7:0];
    if (mem_WE1) mem[17'(mem_A + 17'd1)]   <= mem_WD[15:8];
    if (mem_WE2) mem[17'(mem_A + 17'd2)]   <= mem_WD[23:16];
    if (mem_WE3) mem[17'(mem_A + 17'd3)]   <= mem_WD[31:24];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [16:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #90000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(misaligned_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    RST = 1'b0;
    tick();

    // SW then back-to-back LW
    drive(1'b1, 3'b010, 17'h10004, 32'hDEADBEEF);
    chk("sw_A", 32'(mem_A), 32'h10004);
    chk("sw_WE", 32'(we), 32'hF);
    chk("sw_WD", mem_WD, 32'hDEADBEEF);
    tick();
    chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sw_rsp_rdata", rsp_rdata, 32'd0);
    drive(1'b0, 3'b010, 17'h10004, 32'h0);
    chk("lw_WE", 32'(we), 32'h0);
    tick();
    chk("lw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw_rdata", rsp_rdata, 32'hDEADBEEF);

    // SB then LB / LBU
    drive(1'b1, 3'b000, 17'h10006, 32'h000000A5);
    chk("sb_A", 32'(mem_A), 32'h10004);
    chk("sb_WE", 32'(we), 32'h4);
    chk("sb_WD", mem_WD, 32'h00A50000);
    tick();
    drive(1'b0, 3'b000, 17'h10006, 32'h0);
    tick();
    chk("lb_rdata", rsp_rdata, 32'hFFFFFFA5);
    drive(1'b0, 3'b100, 17'h10006, 32'h0);
    tick();
    chk("lbu_rdata", rsp_rdata, 32'h000000A5);

    // halfwords: word at 0x10004 is now DEA5BEEF
    drive(1'b0, 3'b001, 17'h10004, 32'h0);
    tick();
    chk("lh_rdata", rsp_rdata, 32'hFFFFBEEF);
    drive(1'b0, 3'b101, 17'h10006, 32'h0);
    tick();
    chk("lhu_rdata", rsp_rdata, 32'h0000DEA5);
    drive(1'b1, 3'b001, 17'h10002, 32'hFFFF1234);
    chk("sh_WE", 32'(we), 32'hC);
    chk("sh_WD", mem_WD, 32'h12340000);
    tick();

    // illegal funct3 and store-unsigned
    drive(1'b1, 3'b011, 17'h10000, 32'hFFFFFFFF);
    chk("ill_WE", 32'(we), 32'h0);
    tick();
    chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill_err", 32'(misaligned_err), 32'd0);
    drive(1'b1, 3'b100, 17'h10000, 32'hFFFFFFFF);
    chk("ill_sbu_WE", 32'(we), 32'h0);
    tick();
    chk("ill_sbu_rdata", rsp_rdata, 32'd0);
    idle();
    tick();
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
    // split SW across 0x10000/0x10004
    drive(1'b1, 3'b010, 17'h10003, 32'h11223344);
    chk("spl_b1_A", 32'(mem_A), 32'h10000);
    chk("spl_b1_WE", 32'(we), 32'h8);
    chk("spl_b1_WD", mem_WD, 32'h44000000);
    tick();
    idle();
    #1;
    chk("spl_b2_ready", 32'(req_ready), 32'd0);
    chk("spl_b2_A", 32'(mem_A), 32'h10004);
    chk("spl_b2_WE", 32'(we), 32'h7);
    chk("spl_b2_WD_lo", {8'h00, mem_WD[23:0]}, 32'h00112233);
    chk("spl_b2_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("spl_done_valid", 32'(rsp_valid), 32'd1);
    chk("spl_done_ready", 32'(req_ready), 32'd1);
    drive(1'b0, 3'b010, 17'h10003, 32'h0);
    tick();
    idle();
    #1;
    chk("spl_lw_midvalid", 32'(rsp_valid), 32'd0);
    tick();
    chk("spl_lw_rdata", rsp_rdata, 32'h11223344);

    // LH wrapping past the top of memory
    mem[17'h1FFFF] = 8'h12;
    mem[17'h00000] = 8'h80;
    drive(1'b0, 3'b001, 17'h1FFFF, 32'h0);
    chk("wrap_b1_A", 32'(mem_A), 32'h1FFFC);
    tick();
    idle();
    #1;
    chk("wrap_b2_A", 32'(mem_A), 32'h00000);
    chk("wrap_b2_WE", 32'(we), 32'h0);
    tick();
    chk("wrap_rdata", rsp_rdata, 32'hFFFF8012);

    // reset during BEAT2 of a split SW
    drive(1'b1, 3'b010, 17'h10001, 32'hCAFEF00D);
    chk("rstb2_b1_WE", 32'(we), 32'hE);
    tick();
    idle();
    #1;
    chk("rstb2_inb2_ready", 32'(req_ready), 32'd0);
    RST = 1'b1;
    #1;
    chk("rstb2_ready", 32'(req_ready), 32'd1);
    chk("rstb2_WE", 32'(we), 32'h0);
    tick();
    RST = 1'b0;
    tick();
    chk("rstb2_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rstb2_ready_after", 32'(req_ready), 32'd1);
    chk("rstb2_mem_untouched", 32'(mem[17'h10004]), 32'h33);
    drive(1'b0, 3'b010, 17'h10000, 32'h0);
    tick();
    chk("rstb2_beat1_kept", rsp_rdata, 32'hFEF00D00);
`else
    // misaligned word load and store are rejected with an error
    drive(1'b0, 3'b010, 17'h10002, 32'h0);
    chk("mis_lw_WE", 32'(we), 32'h0);
    chk("mis_lw_ready", 32'(req_ready), 32'd1);
    tick();
    chk("mis_lw_valid", 32'(rsp_valid), 32'd1);
    chk("mis_lw_err", 32'(misaligned_err), 32'd1);
    chk("mis_lw_rdata", rsp_rdata, 32'd0);
    drive(1'b1, 3'b001, 17'h10003, 32'h0000BBAA);
    chk("mis_sh_WE", 32'(we), 32'h0);
    tick();
    chk("mis_sh_err", 32'(misaligned_err), 32'd1);
    drive(1'b0, 3'b010, 17'h10000, 32'h0);
    tick();
    chk("mis_nowrite", rsp_rdata, 32'h12340000);
    chk("mis_err_clear", 32'(misaligned_err), 32'd0);
`endif

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
